// File: rtl/riscv_pkg.sv
// Shared core types for the data-memory path: access size and controller state.
// Latency: n/a (types and pure combinational helpers only).
// Backpressure: n/a.
package riscv_pkg;

    typedef enum logic [1:0] {
        BYTE      = 2'b00,
        HALF_WORD = 2'b01,
        WORD      = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } dmem_state_t;

    // Byte lanes touched by an access; any encoding other than BYTE/HALF_WORD is a word.
    function automatic logic [3:0] dmem_byte_en(input mem_size_t size, input logic [1:0] off);
        logic [3:0] be;
        be = 4'b1111;
        case (size)
            BYTE:      be = 4'b0001 << off;
            HALF_WORD: be = off[1] ? 4'b1100 : 4'b0011;
            default:   be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data arrives right-aligned; copy it across every lane so the byte enables pick it.
    function automatic logic [31:0] dmem_wr_replicate(input mem_size_t size, input logic [31:0] data);
        logic [31:0] r;
        r = data;
        case (size)
            BYTE:      r = {4{data[7:0]}};
            HALF_WORD: r = {2{data[15:0]}};
            default:   r = data;
        endcase
        return r;
    endfunction

    // Pull the addressed byte/half out of the word and sign- or zero-extend it.
    function automatic logic [31:0] dmem_rd_format(input mem_size_t size, input logic zext,
                                                   input logic [1:0] off, input logic [31:0] word);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        shifted = word >> {off, 3'b000};
        b       = shifted[7:0];
        h       = off[1] ? word[31:16] : word[15:0];
        r       = word;
        case (size)
            BYTE:      r = zext ? {24'b0, b} : {{24{b[7]}}, b};
            HALF_WORD: r = zext ? {16'b0, h} : {{16{h[15]}}, h};
            default:   r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_sram.sv
// Single-port word array with per-byte write enables and registered read data.
// Latency: write lands on the enabling edge; read data valid the cycle after rd_en.
// Backpressure: none, one access per cycle; contents are never reset.
module dmem_sram #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rd_en,
    input  logic [3:0]    wr_be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wr_data,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rd_data_q;

    // Byte-lane writes and synchronous read on the same single port.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_be[i]) begin
                mem[addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
        if (rd_en) begin
            rd_data_q <= mem[addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Core data-memory controller: latches one load/store, accesses dmem_sram, returns a one-cycle response.
// Latency: accept cycle -> ACCESS -> RESP; dmem_rsp_valid two cycles after the accepting cycle.
// Backpressure: dmem_ready only in IDLE, so at most one accept every three cycles.
// Build option: define DMEM_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of aligning them.
module dmem_ctrl
    import riscv_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dmem_req,
    input  logic        dmem_wr_en,
    input  mem_size_t   dmem_size,
    input  logic        dmem_zero_extend,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wr_data,
    output logic        dmem_ready,
    output logic        dmem_rsp_valid,
    output logic [31:0] dmem_rd_data,
    output logic        dmem_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    dmem_state_t state_q, state_d;
    logic [31:0] addr_q, addr_d;
    mem_size_t   size_q, size_d;
    logic        wr_q, wr_d;
    logic        zext_q, zext_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        err_q, err_d;

    logic [1:0]  eff_off;
    logic        oor;
    logic        fault;
    logic        acc_en;
    logic [3:0]  sram_be;
    logic [31:0] sram_rdata;

    // Effective lane offset: half/word accesses are forced onto their natural boundary.
    always_comb begin
        eff_off = addr_q[1:0];
        case (size_q)
            BYTE:      eff_off = addr_q[1:0];
            HALF_WORD: eff_off = {addr_q[1], 1'b0};
            default:   eff_off = 2'b00;
        endcase
    end

    assign oor = ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));

`ifdef DMEM_MISALIGN_TRAP_EN
    logic misalign;
    assign misalign = ((size_q == HALF_WORD) && addr_q[0]) ||
                      ((size_q != BYTE) && (size_q != HALF_WORD) && (addr_q[1:0] != 2'b00));
    assign fault    = oor | misalign;
`else
    assign fault    = oor;
`endif

    // rst_n gating keeps a store whose ACCESS edge meets reset from reaching the array.
    assign acc_en  = (state_q == ACCESS) && !fault;
    assign sram_be = (acc_en && wr_q && rst_n) ? dmem_byte_en(size_q, eff_off) : 4'b0000;

    dmem_sram #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_sram (
        .clk     (clk),
        .rd_en   (acc_en && !wr_q),
        .wr_be   (sram_be),
        .addr    (addr_q[AW+1:2]),
        .wr_data (dmem_wr_replicate(size_q, wdata_q)),
        .rd_data (sram_rdata)
    );

    // Next-state and request-latch logic; response flags are produced one edge ahead of RESP.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        size_d      = size_q;
        wr_d        = wr_q;
        zext_d      = zext_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (dmem_req) begin
                    addr_d  = dmem_addr;
                    size_d  = dmem_size;
                    wr_d    = dmem_wr_en;
                    zext_d  = dmem_zero_extend;
                    wdata_d = dmem_wr_data;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                rsp_valid_d = 1'b1;
                err_d       = fault;
                state_d     = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    // Controller state and registered response flags; reset aborts any request in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            size_q      <= BYTE;
            wr_q        <= 1'b0;
            zext_q      <= 1'b0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            wr_q        <= wr_d;
            zext_q      <= zext_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            err_q       <= err_d;
        end
    end

    assign dmem_ready     = (state_q == IDLE);
    assign dmem_rsp_valid = rsp_valid_q;
    assign dmem_err       = err_q;
    assign dmem_rd_data   = (rsp_valid_q && !err_q && !wr_q) ?
                            dmem_rd_format(size_q, zext_q, eff_off, sram_rdata) : 32'h0;

endmodule
